// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] komut;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {pc, komut} entries between the memory port and decode.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  fetch_entry_t                   push_entry,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH + 1)-1:0]   count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Flush only rewinds the pointers; stale storage is masked by count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding imem handshake,
// buffered delivery to decode and redirect handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_update,
  input  logic [31:0] pc_new,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] komut,
  output logic [31:0] komut_pc,
  output logic        komut_valid,
  input  logic        komut_ready,
  output logic [31:0] pc,
  output logic        hata_f
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t  state;
  logic          outstanding;
  logic          discard;
  logic [31:0]   req_pc;

  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] count_next;
  logic          buf_empty;
  logic          buf_full;

  logic fire;
  logic rsp;
  logic redirect_ok;
  logic redirect_bad;
  logic flush;
  logic push;
  logic pop;
  logic room_next;
  logic stale_req;

  // Handshake decode, redirect classification and buffer control.
  always_comb begin
    fire         = (state == FETCH) && imem_req && imem_gnt;
    rsp          = (state == WAIT) && outstanding && imem_rvalid;
    redirect_bad = pc_update && (state != HALT) && (pc_new[1:0] != 2'b00);
    redirect_ok  = pc_update && (state != HALT) && (pc_new[1:0] == 2'b00);
    flush        = redirect_bad || redirect_ok;
    push         = rsp && !discard && !flush && !buf_full;
    pop          = !buf_empty && komut_ready && !flush;
    count_next   = flush ? '0 : CW'(buf_count + CW'(push) - CW'(pop));
    // Requests are only issued from FETCH, where nothing is outstanding.
    room_next    = count_next < CW'(BUF_DEPTH);
    // A request already granted (or granted now) will return a stale word.
    stale_req    = fire || ((state == WAIT) && !rsp);
    push_entry   = '{pc: req_pc, komut: imem_rdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= PC_RESET;
      imem_addr   <= PC_RESET;
      imem_req    <= 1'b0;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      hata_f      <= 1'b0;
    end else if (redirect_bad) begin
      state       <= HALT;
      imem_req    <= 1'b0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      hata_f      <= 1'b1;
    end else if (redirect_ok) begin
      pc        <= pc_new;
      imem_addr <= pc_new;
      if (stale_req) begin
        state       <= WAIT;
        imem_req    <= 1'b0;
        outstanding <= 1'b1;
        discard     <= 1'b1;
      end else begin
        state       <= FETCH;
        imem_req    <= room_next;
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (fire) begin
            state       <= WAIT;
            pc          <= pc + PC_STEP;
            imem_addr   <= pc + PC_STEP;
            req_pc      <= pc;
            imem_req    <= 1'b0;
            outstanding <= 1'b1;
          end else begin
            imem_req <= room_next;
          end
        end
        WAIT: begin
          if (rsp) begin
            state       <= FETCH;
            imem_req    <= room_next;
            outstanding <= 1'b0;
            discard     <= 1'b0;
          end
        end
        HALT:    imem_req <= 1'b0;
        default: state    <= HALT;
      endcase
    end
  end

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .count      (buf_count),
    .empty      (buf_empty),
    .full       (buf_full)
  );

  assign komut       = head.komut;
  assign komut_pc    = head.pc;
  assign komut_valid = !buf_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: cycle table on a PC_RESET=0 instance,
// hand sequence on a wrapping PC_RESET instance.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        pc_update;
  logic [31:0] pc_new;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        komut_ready;

  logic        imem_req,   w_req;
  logic [31:0] imem_addr,  w_addr;
  logic [31:0] komut,      w_komut;
  logic [31:0] komut_pc,   w_kpc;
  logic        komut_valid, w_valid;
  logic [31:0] pc,         w_pc;
  logic        hata_f,     w_hata;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc_update(pc_update), .pc_new(pc_new),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .komut(komut), .komut_pc(komut_pc), .komut_valid(komut_valid),
    .komut_ready(komut_ready), .pc(pc), .hata_f(hata_f)
  );

  fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .pc_update(pc_update), .pc_new(pc_new),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .komut(w_komut), .komut_pc(w_kpc), .komut_valid(w_valid),
    .komut_ready(komut_ready), .pc(w_pc), .hata_f(w_hata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst, gnt, rv, rdy, upd;
    logic [31:0] rdata, pcn;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_kpc, e_komut, e_pc;
    logic        e_hata;
  } vec_t;

  function automatic vec_t mk(input logic rst, gnt, rv, rdy, upd,
                              input logic [31:0] rdata, pcn,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_kpc, e_komut, e_pc,
                              input logic e_hata);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdy = rdy; v.upd = upd;
    v.rdata = rdata; v.pcn = pcn;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_kpc = e_kpc; v.e_komut = e_komut; v.e_pc = e_pc; v.e_hata = e_hata;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic rst, g, rv, rdy, upd, input logic [31:0] rd, pcn);
    @(negedge clk);
    reset = rst; imem_gnt = g; imem_rvalid = rv; komut_ready = rdy;
    pc_update = upd; imem_rdata = rd; pc_new = pcn;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; pc_update = 1'b0; pc_new = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; komut_ready = 1'b0;

    // rst gnt rv rdy upd  rdata  pc_new   | req addr valid kpc komut pc hata
    // Streaming with gnt held and ready held: one word every two cycles.
    tbl.push_back(mk(1,0,0,0,0, 32'h0,          32'h0,   0, 32'h0,   0, 32'h0,   32'h0,          32'h0,   0));
    tbl.push_back(mk(0,1,0,1,0, 32'h0,          32'h0,   1, 32'h0,   0, 32'h0,   32'h0,          32'h0,   0));
    tbl.push_back(mk(0,1,0,1,0, 32'h0,          32'h0,   0, 32'h4,   0, 32'h0,   32'h0,          32'h4,   0));
    tbl.push_back(mk(0,1,1,1,0, 32'hC000_0000,  32'h0,   1, 32'h4,   1, 32'h0,   32'hC000_0000,  32'h4,   0));
    tbl.push_back(mk(0,1,0,1,0, 32'h0,          32'h0,   0, 32'h8,   0, 32'h0,   32'h0,          32'h8,   0));
    tbl.push_back(mk(0,1,1,1,0, 32'hC000_0004,  32'h0,   1, 32'h8,   1, 32'h4,   32'hC000_0004,  32'h8,   0));
    tbl.push_back(mk(0,1,0,1,0, 32'h0,          32'h0,   0, 32'hC,   0, 32'h0,   32'h0,          32'hC,   0));
    tbl.push_back(mk(0,1,1,1,0, 32'hC000_0008,  32'h0,   1, 32'hC,   1, 32'h8,   32'hC000_0008,  32'hC,   0));
    tbl.push_back(mk(0,1,0,1,0, 32'h0,          32'h0,   0, 32'h10,  0, 32'h0,   32'h0,          32'h10,  0));
    tbl.push_back(mk(0,1,1,1,0, 32'hC000_000C,  32'h0,   1, 32'h10,  1, 32'hC,   32'hC000_000C,  32'h10,  0));
    // Back-pressure: buffer fills to two entries, request gated, one pop reopens it at 8.
    tbl.push_back(mk(1,0,0,0,0, 32'h0,          32'h0,   0, 32'h0,   0, 32'h0,   32'h0,          32'h0,   0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,          32'h0,   1, 32'h0,   0, 32'h0,   32'h0,          32'h0,   0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,          32'h0,   0, 32'h4,   0, 32'h0,   32'h0,          32'h4,   0));
    tbl.push_back(mk(0,1,1,0,0, 32'hC000_0000,  32'h0,   1, 32'h4,   1, 32'h0,   32'hC000_0000,  32'h4,   0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,          32'h0,   0, 32'h8,   1, 32'h0,   32'hC000_0000,  32'h8,   0));
    tbl.push_back(mk(0,1,1,0,0, 32'hC000_0004,  32'h0,   0, 32'h8,   1, 32'h0,   32'hC000_0000,  32'h8,   0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,          32'h0,   0, 32'h8,   1, 32'h0,   32'hC000_0000,  32'h8,   0));
    tbl.push_back(mk(0,1,0,1,0, 32'h0,          32'h0,   1, 32'h8,   1, 32'h4,   32'hC000_0004,  32'h8,   0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,          32'h0,   1, 32'h8,   1, 32'h4,   32'hC000_0004,  32'h8,   0));
    // Redirect while waiting: the in-flight word is dropped.
    tbl.push_back(mk(0,1,0,1,0, 32'h0,          32'h0,   0, 32'hC,   0, 32'h0,   32'h0,          32'hC,   0));
    tbl.push_back(mk(0,0,0,0,1, 32'h0,          32'h100, 0, 32'h100, 0, 32'h0,   32'h0,          32'h100, 0));
    tbl.push_back(mk(0,0,1,0,0, 32'hC000_0008,  32'h0,   1, 32'h100, 0, 32'h0,   32'h0,          32'h100, 0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,          32'h0,   0, 32'h104, 0, 32'h0,   32'h0,          32'h104, 0));
    tbl.push_back(mk(0,0,1,0,0, 32'hC000_0100,  32'h0,   1, 32'h104, 1, 32'h100, 32'hC000_0100,  32'h104, 0));
    // Redirect in the rvalid cycle: word not pushed, nothing dropped later.
    tbl.push_back(mk(0,1,0,0,0, 32'h0,          32'h0,   0, 32'h108, 1, 32'h100, 32'hC000_0100,  32'h108, 0));
    tbl.push_back(mk(0,0,1,1,1, 32'hC000_0104,  32'h200, 1, 32'h200, 0, 32'h0,   32'h0,          32'h200, 0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,          32'h0,   0, 32'h204, 0, 32'h0,   32'h0,          32'h204, 0));
    tbl.push_back(mk(0,0,1,0,0, 32'hC000_0200,  32'h0,   1, 32'h204, 1, 32'h200, 32'hC000_0200,  32'h204, 0));
    // Redirect together with a grant: target is not incremented, response is stale.
    tbl.push_back(mk(0,1,0,0,1, 32'h0,          32'h300, 0, 32'h300, 0, 32'h0,   32'h0,          32'h300, 0));
    tbl.push_back(mk(0,0,1,0,0, 32'hC000_0204,  32'h0,   1, 32'h300, 0, 32'h0,   32'h0,          32'h300, 0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,          32'h0,   0, 32'h304, 0, 32'h0,   32'h0,          32'h304, 0));
    tbl.push_back(mk(0,0,1,0,0, 32'hC000_0300,  32'h0,   1, 32'h304, 1, 32'h300, 32'hC000_0300,  32'h304, 0));
    // Misaligned target: sticky error, halted until reset.
    tbl.push_back(mk(0,0,0,0,1, 32'h0,          32'h102, 0, 32'h304, 0, 32'h0,   32'h0,          32'h304, 1));
    tbl.push_back(mk(0,1,1,1,1, 32'hDEAD_0000,  32'h400, 0, 32'h304, 0, 32'h0,   32'h0,          32'h304, 1));
    tbl.push_back(mk(0,1,0,1,0, 32'h0,          32'h0,   0, 32'h304, 0, 32'h0,   32'h0,          32'h304, 1));
    tbl.push_back(mk(1,0,0,0,0, 32'h0,          32'h0,   0, 32'h0,   0, 32'h0,   32'h0,          32'h0,   0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,          32'h0,   1, 32'h0,   0, 32'h0,   32'h0,          32'h0,   0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].gnt, tbl[i].rv, tbl[i].rdy, tbl[i].upd, tbl[i].rdata, tbl[i].pcn);
      n_vec++;
      chk("imem_req",    i, 32'(imem_req),    32'(tbl[i].e_req));
      chk("imem_addr",   i, imem_addr,        tbl[i].e_addr);
      chk("komut_valid", i, 32'(komut_valid), 32'(tbl[i].e_valid));
      chk("pc",          i, pc,               tbl[i].e_pc);
      chk("hata_f",      i, 32'(hata_f),      32'(tbl[i].e_hata));
      if (tbl[i].e_valid) begin
        chk("komut_pc", i, komut_pc, tbl[i].e_kpc);
        chk("komut",    i, komut,    tbl[i].e_komut);
      end
    end

    // Wrapping PC from a high reset value.
    drive(1,0,0,0,0, 32'h0, 32'h0);
    n_vec++;
    chk("w_rst_pc",   100, w_pc,          32'hFFFF_FFF8);
    chk("w_rst_addr", 100, w_addr,        32'hFFFF_FFF8);
    chk("w_rst_req",  100, 32'(w_req),    32'h0);
    drive(0,1,0,1,0, 32'h0, 32'h0);
    n_vec++;
    chk("w_req",      101, 32'(w_req),    32'h1);
    chk("w_addr",     101, w_addr,        32'hFFFF_FFF8);
    drive(0,1,0,1,0, 32'h0, 32'h0);
    n_vec++;
    chk("w_pc",       102, w_pc,          32'hFFFF_FFFC);
    drive(0,1,1,1,0, 32'hAAAA_0001, 32'h0);
    n_vec++;
    chk("w_valid",    103, 32'(w_valid),  32'h1);
    chk("w_kpc",      103, w_kpc,         32'hFFFF_FFF8);
    chk("w_komut",    103, w_komut,       32'hAAAA_0001);
    drive(0,1,0,1,0, 32'h0, 32'h0);
    n_vec++;
    chk("w_pc_wrap",  104, w_pc,          32'h0);
    drive(0,1,1,1,0, 32'hAAAA_0002, 32'h0);
    n_vec++;
    chk("w_kpc",      105, w_kpc,         32'hFFFF_FFFC);
    drive(0,1,0,1,0, 32'h0, 32'h0);
    n_vec++;
    chk("w_pc",       106, w_pc,          32'h4);
    drive(0,1,1,1,0, 32'hAAAA_0003, 32'h0);
    n_vec++;
    chk("w_kpc",      107, w_kpc,         32'h0);
    chk("w_komut",    107, w_komut,       32'hAAAA_0003);
    drive(0,1,0,1,0, 32'h0, 32'h0);
    n_vec++;
    chk("w_pc",       108, w_pc,          32'h8);
    chk("w_valid",    108, 32'(w_valid),  32'h0);

    // Asynchronous reset mid-WAIT, then a late rvalid that must be ignored.
    #2 reset = 1'b1;
    #1;
    n_vec++;
    chk("w_async_req",   109, 32'(w_req),   32'h0);
    chk("w_async_pc",    109, w_pc,         32'hFFFF_FFF8);
    chk("w_async_addr",  109, w_addr,       32'hFFFF_FFF8);
    chk("w_async_valid", 109, 32'(w_valid), 32'h0);
    chk("w_async_komut", 109, w_komut,      32'h0);
    chk("w_async_kpc",   109, w_kpc,        32'h0);
    chk("w_async_hata",  109, 32'(w_hata),  32'h0);
    drive(0,0,1,1,0, 32'hBBBB_0000, 32'h0);
    n_vec++;
    chk("w_late_valid", 110, 32'(w_valid), 32'h0);
    chk("w_late_req",   110, 32'(w_req),   32'h1);
    chk("w_late_addr",  110, w_addr,       32'hFFFF_FFF8);
    drive(0,0,0,0,0, 32'h0, 32'h0);
    n_vec++;
    chk("w_late_valid2", 111, 32'(w_valid), 32'h0);
    chk("w_late_pc",     111, w_pc,         32'hFFFF_FFF8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
